io_handshake_port: RTL and testbench
====================================

// Module: io_handshake_port
// PURPOSE
//  CPU-side responder for the button/switch operator I/O handshake. CPU raises io_req;
//  block stalls the CPU (io_pause) until operator presses the debounced button, then
//  either captures the switches (input) or releases a value shown on the displays (output).
//  Sits between Debouncer output and the CPU; disp_data feeds the seven-segment converters.
// PARAMETERS
//  DATA_W      16  width of switches, read data and display data
//  ARM_CYCLES  4   consecutive button-released cycles required before a press is accepted (>=1)
// PORTS
//  clk         in   1       system clock; all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  button_db   in   1       debounced button level, synchronous to clk
//  switches    in   DATA_W  operator switch bank
//  io_req      in   1       CPU I/O request, sampled only in IDLE
//  io_type     in   1       0 = input (read switches), 1 = output (display io_wdata); sampled with io_req
//  io_wdata    in   DATA_W  CPU output value; sampled with io_req
//  io_pause    out  1       CPU stall; high while a request is outstanding
//  io_rdata    out  DATA_W  switches captured by the last completed input transfer
//  io_done     out  1       one-cycle pulse: transfer complete
//  disp_data   out  DATA_W  value for display converters
//  disp_valid  out  1       disp_data holds a CPU output value
//  state       out  2       current FSM state (debug display)
// BEHAVIOUR
//  Reset (async, any time incl. mid-transfer): state=IDLE, arm counter=0, button_q=0,
//   io_rdata=0, disp_data=0, disp_valid=0, io_done=0; io_pause=0 once io_req is low.
//  rise = button_db & ~button_q; button_q registers button_db every cycle.
//  FSM:
//   IDLE: io_req=1 -> latch type; if output: disp_data<=io_wdata, disp_valid<=1;
//         if input: disp_valid<=0; arm counter<=0; -> ARM. Else stay.
//   ARM:  button_db=1 -> counter<=0; button_db=0 -> counter++; when counter==ARM_CYCLES-1
//         and button_db=0 -> WAIT. A held button never completes a transfer.
//   WAIT: rise=1 -> if input: io_rdata<=switches (value in that cycle); -> DONE.
//   DONE: io_done=1 for exactly this cycle; -> IDLE unconditionally.
//  io_pause (combinational) = (state==ARM)|(state==WAIT)|(state==IDLE & io_req).
//   Low in DONE, so CPU resumes in the same cycle io_done is high.
//  io_req in ARM/WAIT/DONE is ignored (no queueing); a new request is accepted in IDLE
//   the cycle after DONE at the earliest.
//  Latency: request -> earliest io_done = ARM_CYCLES + 2 cycles (button low throughout,
//   rise on first WAIT cycle).
//  io_rdata and disp_data hold their values across transfers until overwritten;
//   disp_data is unchanged by input transfers.
//  Arm counter width = clog2(ARM_CYCLES)+1; saturates, never wraps.
//  state encoding: IDLE=0, ARM=1, WAIT=2, DONE=3.
// STRUCTURE
//  Shared package io_port_pkg: state localparams (IDLE/ARM/WAIT/DONE), IO_TYPE_IN=1'b0,
//   IO_TYPE_OUT=1'b1.
//  One sub-module: rise_detector (clk, rst, level -> rise, registered button_q).
//  FSM, arm counter and data latches stay in this module.
// TESTING
//  1 Reset: assert rst mid-WAIT -> state=0, io_pause=0, io_rdata=0, disp_valid=0 immediately.
//  2 Input: switches=16'hBEEF, io_req/io_type=0, button low 4 cycles then pulse
//    -> io_rdata=16'hBEEF, io_done 1 cycle, io_pause low in that cycle; total = 6 cycles.
//  3 Output: io_req, io_type=1, io_wdata=16'h1234 -> disp_data=16'h1234, disp_valid=1 next
//    cycle; io_pause held until press; disp_data retained after io_done.
//  4 Held button: button_db high before and through io_req -> no io_done until release for
//    4 cycles and a fresh press; a release of only 3 cycles then press -> still stalled.
//  5 Ignored request: pulse io_req with io_wdata=16'hFFFF during WAIT -> disp_data unchanged,
//    only one io_done.
//  6 Back-to-back: io_req held high through DONE -> second transfer starts in the IDLE cycle
//    after DONE; switches change mid-ARM -> io_rdata takes value at the press cycle.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared types for the operator I/O handshake port: FSM state encoding and transfer direction.
// No latency or backpressure; declarations only.
package io_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } io_state_e;

    localparam logic IO_TYPE_IN  = 1'b0;
    localparam logic IO_TYPE_OUT = 1'b1;

    // Arm counter needs one spare bit so it can saturate above ARM_CYCLES-1.
    function automatic int arm_cnt_w(input int arm_cycles);
        return $clog2(arm_cycles) + 1;
    endfunction

endpackage

// File: rtl/io_handshake_port_if.sv
// CPU / operator-panel signal bundle for io_handshake_port.
// No latency; io_pause is the only backpressure toward the CPU.
interface io_handshake_port_if #(
    parameter int DATA_W = 16
);
    logic              button_db;
    logic [DATA_W-1:0] switches;
    logic              io_req;
    logic              io_type;
    logic [DATA_W-1:0] io_wdata;
    logic              io_pause;
    logic [DATA_W-1:0] io_rdata;
    logic              io_done;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic [1:0]        state;

    modport master (
        output button_db, switches, io_req, io_type, io_wdata,
        input  io_pause, io_rdata, io_done, disp_data, disp_valid, state
    );

    modport slave (
        input  button_db, switches, io_req, io_type, io_wdata,
        output io_pause, io_rdata, io_done, disp_data, disp_valid, state
    );
endinterface

// File: rtl/io_handshake_port_rise_detector.sv
// Rising-edge detector on a level already synchronous to clk.
// rise is combinational from the current level and last cycle's level; no backpressure.
module rise_detector (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic level_q;
    logic level_d;

    always_comb begin
        level_d = level;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign rise = level & ~level_q;
endmodule

// File: rtl/io_handshake_port.sv
// CPU-side responder: stalls the CPU on io_req until an armed button press, then captures switches or shows io_wdata.
// Request to io_done is ARM_CYCLES+2 cycles at best; io_pause holds the CPU for the whole transfer.
module io_handshake_port
    import io_port_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ARM_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    io_handshake_port_if.slave  port
);
    localparam int                CNT_W    = arm_cnt_w(ARM_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    io_state_e         state_q, state_d;
    logic              type_q, type_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic              dvalid_q, dvalid_d;
    logic              rise;

    rise_detector u_rise (
        .clk   (clk),
        .rst   (rst),
        .level (port.button_db),
        .rise  (rise)
    );

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        disp_d   = disp_q;
        dvalid_d = dvalid_q;
        case (state_q)
            IDLE: begin
                if (port.io_req) begin
                    type_d = port.io_type;
                    cnt_d  = '0;
                    if (port.io_type == IO_TYPE_OUT) begin
                        disp_d   = port.io_wdata;
                        dvalid_d = 1'b1;
                    end else begin
                        dvalid_d = 1'b0;
                    end
                    state_d = ARM;
                end
            end
            ARM: begin
                // Any cycle with the button down restarts the release window.
                if (port.button_db) begin
                    cnt_d = '0;
                end else begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = WAIT;
                    end
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (rise) begin
                    if (type_q == IO_TYPE_IN) begin
                        rdata_d = port.switches;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            type_q   <= IO_TYPE_IN;
            cnt_q    <= '0;
            rdata_q  <= '0;
            disp_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            disp_q   <= disp_d;
            dvalid_q <= dvalid_d;
        end
    end

    // Pause drops in DONE so the CPU resumes in the same cycle io_done pulses.
    assign port.io_pause   = (state_q == ARM) | (state_q == WAIT) |
                             ((state_q == IDLE) & port.io_req);
    assign port.io_done    = (state_q == DONE);
    assign port.io_rdata   = rdata_q;
    assign port.disp_data  = disp_q;
    assign port.disp_valid = dvalid_q;
    assign port.state      = state_q;
endmodule

// File: tb/tb_io_handshake_port.sv
// Randomized and directed bench for io_handshake_port against a history-based transfer model.
module tb_io_handshake_port;
    localparam int DW  = 16;
    localparam int ARM = 4;
    localparam int HIST = 16384;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_handshake_port_if #(.DATA_W(DW)) io();

    io_handshake_port #(.DATA_W(DW), .ARM_CYCLES(ARM)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (io)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: a transfer is described by its acceptance cycle, the cycle its
    // press window opens and the cycle it completes; button history is kept raw.
    bit          btn_hist [0:HIST-1];
    int          cyc_n = 0;
    bit          m_busy;
    int          m_acc;
    bit          m_type;
    int          m_wait_start;
    int          m_done_cyc;
    logic [15:0] m_rdata;
    logic [15:0] m_disp;
    bit          m_dvalid;
    bit          m_prev;
    int          done_cnt = 0;
    int          last_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy       = 1'b0;
        m_acc        = 0;
        m_type       = 1'b0;
        m_wait_start = -1;
        m_done_cyc   = -1;
        m_rdata      = '0;
        m_disp       = '0;
        m_dvalid     = 1'b0;
        m_prev       = 1'b0;
    endtask

    function automatic int m_phase();
        if (!m_busy)                                    return 0;
        if (cyc_n == m_done_cyc)                        return 3;
        if (m_wait_start >= 0 && cyc_n >= m_wait_start) return 2;
        return 1;
    endfunction

    task automatic cyc(input bit req, input bit typ, input logic [15:0] wd,
                       input bit btn, input logic [15:0] sw);
        int ph;
        bit quiet;
        io.io_req    = req;
        io.io_type   = typ;
        io.io_wdata  = wd;
        io.button_db = btn;
        io.switches  = sw;
        @(negedge clk);
        ph = m_phase();
        chk("state",      {30'd0, io.state}, ph);
        chk("io_pause",   io.io_pause, (ph == 1 || ph == 2 || (ph == 0 && req)) ? 1 : 0);
        chk("io_done",    io.io_done,  (ph == 3) ? 1 : 0);
        chk("io_rdata",   io.io_rdata, m_rdata);
        chk("disp_data",  io.disp_data, m_disp);
        chk("disp_valid", io.disp_valid, m_dvalid);
        if (io.io_done === 1'b1) begin
            done_cnt++;
            last_done = cyc_n;
        end
        if (cyc_n < HIST) btn_hist[cyc_n] = btn;
        case (ph)
            0: if (req) begin
                m_busy = 1'b1;
                m_acc  = cyc_n;
                m_type = typ;
                if (typ) begin
                    m_disp   = wd;
                    m_dvalid = 1'b1;
                end else begin
                    m_dvalid = 1'b0;
                end
            end
            1: if (cyc_n - m_acc >= ARM) begin
                quiet = 1'b1;
                for (int k = cyc_n - ARM + 1; k <= cyc_n; k++)
                    if (btn_hist[k]) quiet = 1'b0;
                if (quiet) m_wait_start = cyc_n + 1;
            end
            2: if (btn && !m_prev) begin
                if (!m_type) m_rdata = sw;
                m_done_cyc = cyc_n + 1;
            end
            default: begin
                m_busy       = 1'b0;
                m_wait_start = -1;
                m_done_cyc   = -1;
            end
        endcase
        m_prev = btn;
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_check();
        rst       = 1'b1;
        io.io_req = 1'b0;
        #1;
        chk("rst_state",  {30'd0, io.state}, 0);
        chk("rst_pause",  io.io_pause, 0);
        chk("rst_done",   io.io_done, 0);
        chk("rst_rdata",  io.io_rdata, 0);
        chk("rst_disp",   io.disp_data, 0);
        chk("rst_dvalid", io.disp_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1, r0;
        int run;
        bit lvl;
        io.button_db = 1'b0;
        io.switches  = '0;
        io.io_req    = 1'b0;
        io.io_type   = 1'b0;
        io.io_wdata  = '0;
        model_reset();
        do_reset_check();

        // Input transfer, minimum latency.
        r0 = cyc_n;
        cyc(1, 0, 16'h0, 0, 16'hBEEF);
        repeat (4) cyc(0, 0, 16'h0, 0, 16'hBEEF);
        cyc(0, 0, 16'h0, 1, 16'hBEEF);
        cyc(0, 0, 16'h0, 1, 16'h0000);
        chk("t2_lat", last_done - r0, 6);
        chk("t2_rdata", io.io_rdata, 16'hBEEF);
        cyc(0, 0, 16'h0, 0, 16'h0);

        // Output transfer with a long stall.
        cyc(1, 1, 16'h1234, 0, 16'h0);
        chk("t3_disp", io.disp_data, 16'h1234);
        chk("t3_dvalid", io.disp_valid, 1);
        repeat (8) cyc(0, 0, 16'h0, 0, 16'h0);
        cyc(0, 0, 16'h0, 1, 16'h0);
        cyc(0, 0, 16'h0, 1, 16'h0);
        repeat (2) cyc(0, 0, 16'h0, 0, 16'h0);
        chk("t3_disp_kept", io.disp_data, 16'h1234);

        // Reset in the middle of WAIT.
        cyc(1, 1, 16'h7777, 0, 16'h0);
        repeat (5) cyc(0, 0, 16'h0, 0, 16'h0);
        do_reset_check();

        // Held button, short release, then a proper release and press.
        d0 = done_cnt;
        repeat (2) cyc(0, 0, 16'h0, 1, 16'hA5A5);
        cyc(1, 0, 16'h0, 1, 16'hA5A5);
        repeat (5) cyc(0, 0, 16'h0, 1, 16'hA5A5);
        repeat (3) cyc(0, 0, 16'h0, 0, 16'hA5A5);
        repeat (2) cyc(0, 0, 16'h0, 1, 16'hA5A5);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_pause", io.io_pause, 1);
        repeat (4) cyc(0, 0, 16'h0, 0, 16'hA5A5);
        cyc(0, 0, 16'h0, 1, 16'hA5A5);
        cyc(0, 0, 16'h0, 1, 16'h0);
        chk("t4_done", done_cnt - d0, 1);
        chk("t4_rdata", io.io_rdata, 16'hA5A5);
        cyc(0, 0, 16'h0, 0, 16'h0);

        // Requests during WAIT are ignored.
        d0 = done_cnt;
        cyc(1, 1, 16'h5A5A, 0, 16'h0);
        repeat (4) cyc(0, 0, 16'h0, 0, 16'h0);
        repeat (2) cyc(1, 1, 16'hFFFF, 0, 16'h0);
        cyc(0, 0, 16'h0, 1, 16'h0);
        cyc(0, 0, 16'h0, 1, 16'h0);
        repeat (3) cyc(0, 0, 16'h0, 0, 16'h0);
        chk("t5_disp", io.disp_data, 16'h5A5A);
        chk("t5_one_done", done_cnt - d0, 1);

        // Back-to-back with io_req held through DONE; switches move mid-ARM.
        cyc(1, 0, 16'h0, 0, 16'h1111);
        repeat (2) cyc(1, 0, 16'h0, 0, 16'h1111);
        repeat (2) cyc(1, 0, 16'h0, 0, 16'h2222);
        cyc(1, 0, 16'h0, 1, 16'h3333);
        cyc(1, 0, 16'h0, 1, 16'h4444);
        d0 = last_done;
        chk("t6_rdata1", io.io_rdata, 16'h3333);
        cyc(1, 0, 16'h0, 0, 16'h5555);
        repeat (4) cyc(0, 0, 16'h0, 0, 16'h6666);
        cyc(0, 0, 16'h0, 1, 16'h7777);
        cyc(0, 0, 16'h0, 1, 16'h8888);
        d1 = last_done;
        chk("t6_b2b", d1 - d0, 7);
        chk("t6_rdata2", io.io_rdata, 16'h7777);

        // Random traffic: button held in runs so arm windows both succeed and fail.
        run = 0;
        lvl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (run == 0) begin
                lvl = ~lvl;
                run = $urandom_range(1, 6);
            end
            run--;
            cyc($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 16'($urandom),
                lvl, 16'($urandom));
        end
        repeat (12) cyc(0, 0, 16'h0, 0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
